// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: shared UART frame types, line levels and data-bit clamp helper
package uart_tx_scheduler_pkg;
  localparam int DATA_WIDTH = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [1:0] {STOP_ONE = 2'd1, STOP_TWO = 2'd2} stopBitEnum;
  typedef enum logic [3:0] {DATA_5 = 4'd5, DATA_6 = 4'd6, DATA_7 = 4'd7, DATA_8 = 4'd8} dataTypeEnum;
  typedef enum logic [2:0] {IDLE, STARTBIT, DATABITS, PARITYBIT, STOPBIT1, STOPBIT2} UartSchedStateEnum;
  function automatic dataTypeEnum clampBits(logic [3:0] b);
    return b < 4'd5 ? DATA_5 : b > 4'd8 ? DATA_8 : dataTypeEnum'(b);
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester valid/data/ready bus shared by NUM_REQ Tx agents
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = uart_tx_scheduler_pkg::DATA_WIDTH
);
  logic [NUM_REQ-1:0] reqValid;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0] reqReady;
  modport master(output reqValid, output reqData, input reqReady);
  modport slave(input reqValid, input reqData, output reqReady);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// uart_rr_arbiter: round-robin grant searching upward from a pointer that moves past each winner
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] reqValid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grantIdx,
  output logic               anyValid
);
  import uart_tx_scheduler_pkg::*;
  logic [IW-1:0] ptr, idx;
  always_comb begin
    grantIdx = '0;
    anyValid = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!anyValid && reqValid[idx]) begin
        anyValid = 1'b1;
        grantIdx = idx;
      end
    end
    grant = anyValid ? NUM_REQ'(1) << grantIdx : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (advance) ptr <= grantIdx == IW'(NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin shared UART transmitter with internal baud counter.
// Define UART_TX_SCHED_PARITY_ERR_INJ_EN to let cfgParityErrInj invert the parity bit.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = uart_tx_scheduler_pkg::DATA_WIDTH,
  parameter int DIV_WIDTH = 16,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_scheduler_if.slave   req,
  input  logic [DIV_WIDTH-1:0] cfgBaudDiv,
  input  logic [3:0]           cfgDataBits,
  input  logic                 cfgParityEn,
  input  logic                 cfgParityOdd,
  input  logic [1:0]           cfgStopBits,
  input  logic                 cfgParityErrInj,
  output logic                 txOut,
  output logic                 busy,
  output logic [IW-1:0]        grantId,
  output logic                 frameDone
);
  import uart_tx_scheduler_pkg::*;
  UartSchedStateEnum state;
  logic [DIV_WIDTH-1:0] div, cnt, divEff;
  logic [DATA_WIDTH-1:0] dataReg, dataNew, mask;
  logic [3:0] nBits, bitIdx;
  dataTypeEnum nNew;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] gIdx;
  logic anyValid, idle, bitEnd, lastStop, inj, parNew, parityBit, parEn, twoStop;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) arb (
    .clk(clk), .reset(reset), .reqValid(req.reqValid), .advance(idle && anyValid),
    .grant(grant), .grantIdx(gIdx), .anyValid(anyValid)
  );

`ifdef UART_TX_SCHED_PARITY_ERR_INJ_EN
  assign inj = cfgParityErrInj;
`else
  assign inj = 1'b0 & cfgParityErrInj;
`endif

  // Everything the frame needs is resolved at grant so later cfg changes cannot leak in.
  always_comb begin
    nNew = clampBits(cfgDataBits);
    divEff = cfgBaudDiv < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : cfgBaudDiv;
    dataNew = req.reqData[gIdx*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < DATA_WIDTH; i++) mask[i] = i < int'(nNew);
    parNew = ^(dataNew & mask) ^ cfgParityOdd ^ inj;
  end

  assign idle = state == IDLE;
  assign busy = !idle;
  assign bitEnd = cnt == '0;
  assign lastStop = state == STOPBIT2 || (state == STOPBIT1 && !twoStop);
  assign req.reqReady = idle && reset ? grant : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      txOut <= STOP_BIT;
      grantId <= '0;
      frameDone <= 1'b0;
      cnt <= '0;
      div <= '0;
      dataReg <= '0;
      nBits <= '0;
      bitIdx <= '0;
      parityBit <= 1'b0;
      parEn <= 1'b0;
      twoStop <= 1'b0;
    end else begin
      frameDone <= lastStop && cnt == DIV_WIDTH'(1);
      cnt <= bitEnd ? div - 1'b1 : cnt - 1'b1;
      case (state)
        IDLE: begin
          cnt <= divEff - 1'b1;
          if (anyValid) begin
            state <= STARTBIT;
            txOut <= START_BIT;
            grantId <= gIdx;
            div <= divEff;
            dataReg <= dataNew;
            nBits <= nNew;
            parityBit <= parNew;
            parEn <= cfgParityEn;
            twoStop <= cfgStopBits == STOP_TWO;
          end
        end
        STARTBIT: if (bitEnd) begin
          state <= DATABITS;
          txOut <= dataReg[0];
          dataReg <= dataReg >> 1;
          bitIdx <= '0;
        end
        DATABITS: if (bitEnd) begin
          if (bitIdx == nBits - 1'b1) begin
            state <= parEn ? PARITYBIT : STOPBIT1;
            txOut <= parEn ? parityBit : STOP_BIT;
          end else begin
            bitIdx <= bitIdx + 1'b1;
            txOut <= dataReg[0];
            dataReg <= dataReg >> 1;
          end
        end
        PARITYBIT: if (bitEnd) begin
          state <= STOPBIT1;
          txOut <= STOP_BIT;
        end
        STOPBIT1: if (bitEnd) state <= twoStop ? STOPBIT2 : IDLE;
        STOPBIT2: if (bitEnd) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
